apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//  Upstream APB requester for the two-peripheral subsystem: accepts single read/write commands on a
//  valid/ready port and runs one APB3 transfer (SETUP then ACCESS) to peripheral 0 (apb_adder) or
//  peripheral 1, chosen by one address bit. Muxes PRDATA/PREADY/PSLVERR back from the selected slave,
//  returns a one-cycle response pulse, and aborts transfers whose slave never asserts PREADY.
// PARAMETERS
//  ADDR_W    32   width of cmd_addr / PADDR
//  DATA_W    32   width of write/read data
//  SEL_BIT   15   address bit selecting the slave: 0 -> slave 0, 1 -> slave 1 (adder decodes PADDR[14:13])
//  TIMEOUT   16   consecutive ACCESS cycles with PREADY low before abort (>=1)
// PORTS
//  PCLK       in   1       clock; all logic on rising edge
//  PRESET     in   1       synchronous, active-high reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       command accepted when cmd_valid & cmd_ready
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  target address (full value driven on PADDR)
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle pulse: transfer finished
//  rsp_rdata  out  DATA_W  read data (0 for writes, timeouts, and errored reads)
//  rsp_err    out  1       PSLVERR seen, or timeout; valid with rsp_valid
//  PSEL0/PSEL1 out 1       per-slave select
//  PENABLE    out  1       APB enable, shared
//  PWRITE     out  1       APB direction, shared
//  PADDR      out  ADDR_W  APB address, shared
//  PWDATA     out  DATA_W  APB write data, shared
//  PREADY0/1  in   1       slave ready
//  PRDATA0/1  in   DATA_W  slave read data
//  PSLVERR0/1 in   1       slave error
// BEHAVIOUR
//  - Reset (PRESET=1 at edge): state IDLE, timeout counter 0; PSEL0/1, PENABLE, PWRITE, PADDR, PWDATA,
//    rsp_valid, rsp_rdata, rsp_err all 0. cmd_ready = (state==IDLE) & ~PRESET, so it is 0 during reset.
//  - FSM: IDLE -> SETUP on accept; SETUP -> ACCESS unconditionally after 1 cycle;
//    ACCESS -> IDLE when sel PREADY=1 or timeout; otherwise stay in ACCESS.
//  - Accept at edge N: latch write/addr/wdata into PWRITE/PADDR/PWDATA; cycle N+1 SETUP (PSELx=1,
//    PENABLE=0); N+2 onward ACCESS (PSELx=1, PENABLE=1). PADDR/PWDATA/PWRITE stay stable until the
//    next accept, and also hold in IDLE. Exactly one PSELx is high: x = cmd_addr[SEL_BIT].
//  - Completion: the first ACCESS cycle with PREADYx=1. At that edge PSELx and PENABLE drop, and
//    rsp_valid=1 for 1 cycle: rsp_err=PSLVERRx, rsp_rdata = read & ~PSLVERRx ? PRDATAx : 0.
//    Zero-wait slave: accept N -> rsp_valid at N+3.
//  - Back-to-back: cmd_ready is 1 in the rsp_valid cycle, so the next accept may coincide with it. No response backpressure.
//  - Unselected slave inputs are ignored entirely. PSLVERR is sampled only in the completion cycle.
//  - Timeout: the counter increments on each ACCESS cycle with PREADYx=0 and clears on accept. When
//    the count reaches TIMEOUT, the next edge aborts: IDLE, PSELx/PENABLE=0, rsp_valid=1, rsp_err=1,
//    rsp_rdata=0. A PREADYx=1 arriving in that same cycle wins (normal completion).
//  - Reset mid-transfer: abandon the transfer; no rsp_valid is produced; outputs go to reset values at the edge.
// TESTING
//  1 write addr 0x0000_0000 data 0x5, PREADY0=1 -> PSEL0 high N+1..N+2, PENABLE N+2, PSEL1 never, rsp_valid N+3, err=0
//  2 read 0x0000_8000, PREADY1 low 3 ACCESS cycles, PRDATA1=0xDEAD_BEEF -> ACCESS 4 cycles, rsp_rdata=0xDEAD_BEEF
//  3 read slave0, PREADY0 stuck 0 -> 16 ACCESS cycles then rsp_valid, rsp_err=1, rsp_rdata=0, PSEL0 falls
//  4 with apb_adder: write 0x0C to 0x4000, then read 0x0000 accepted in rsp_valid cycle -> rsp_rdata=0x0C
//  5 write slave1 with PSLVERR1=1 at completion -> rsp_err=1, rsp_rdata=0; next command proceeds normally
//  6 PRESET pulse during ACCESS -> PSEL/PENABLE 0 after edge, no rsp_valid, cmd_ready=1 first cycle after release

Source files
------------

// File: rtl/apb_master_bridge.sv
// Purpose: bridges single valid/ready read/write commands onto one APB3 transfer to one of two slaves.
// Latency: accept at edge N -> SETUP N+1 -> ACCESS N+2.. ; zero-wait slave gives rsp_valid at N+3.
// Backpressure: cmd_ready only in IDLE (including the rsp_valid cycle); responses cannot be stalled.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = 15,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL0,
  output logic              PSEL1,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY0,
  input  logic              PREADY1,
  input  logic [DATA_W-1:0] PRDATA0,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic              PSLVERR0,
  input  logic              PSLVERR1
);

  // Wide enough to hold TIMEOUT itself: the abort edge loads the full count.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt, tmo_inc;
  logic              psel0_nxt, psel1_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              accept;
  logic              sel;
  logic              sel_ready;
  logic              sel_slverr;
  logic [DATA_W-1:0] sel_rdata;

  assign cmd_ready = (state == ST_IDLE) & ~PRESET;
  assign accept    = cmd_valid & cmd_ready;

  // The latched address decides which slave's return signals matter; the other is ignored.
  assign sel        = PADDR[SEL_BIT];
  assign sel_ready  = sel ? PREADY1  : PREADY0;
  assign sel_slverr = sel ? PSLVERR1 : PSLVERR0;
  assign sel_rdata  = sel ? PRDATA1  : PRDATA0;
  assign tmo_inc    = tmo_cnt + CNT_W'(1);

  // Next-state and next-output decode; every registered output is computed here.
  always_comb begin
    state_nxt     = state;
    tmo_cnt_nxt   = tmo_cnt;
    psel0_nxt     = PSEL0;
    psel1_nxt     = PSEL1;
    penable_nxt   = PENABLE;
    pwrite_nxt    = PWRITE;
    paddr_nxt     = PADDR;
    pwdata_nxt    = PWDATA;
    rsp_valid_nxt = 1'b0;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt   = ST_SETUP;
          tmo_cnt_nxt = '0;
          pwrite_nxt  = cmd_write;
          paddr_nxt   = cmd_addr;
          pwdata_nxt  = cmd_wdata;
          psel0_nxt   = ~cmd_addr[SEL_BIT];
          psel1_nxt   = cmd_addr[SEL_BIT];
        end
      end
      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          // Normal completion; also wins over a timeout landing in the same cycle.
          state_nxt     = ST_IDLE;
          psel0_nxt     = 1'b0;
          psel1_nxt     = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = sel_slverr;
          rsp_rdata_nxt = (~PWRITE & ~sel_slverr) ? sel_rdata : '0;
        end else begin
          tmo_cnt_nxt = tmo_inc;
          if (tmo_inc == CNT_W'(TIMEOUT)) begin
            state_nxt     = ST_IDLE;
            psel0_nxt     = 1'b0;
            psel1_nxt     = 1'b0;
            penable_nxt   = 1'b0;
            rsp_valid_nxt = 1'b1;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any transfer without a response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= ST_IDLE;
      tmo_cnt   <= '0;
      PSEL0     <= 1'b0;
      PSEL1     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      PSEL0     <= psel0_nxt;
      PSEL1     <= psel1_nxt;
      PENABLE   <= penable_nxt;
      PWRITE    <= pwrite_nxt;
      PADDR     <= paddr_nxt;
      PWDATA    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Purpose: directed scenarios for apb_master_bridge with small behavioural APB slaves.
// Latency: checks cycle counts from accept to rsp_valid and APB phase lengths.
// Backpressure: slave wait states programmed per scenario; responses are never stalled.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL0, PSEL1, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic        PREADY0, PREADY1, PSLVERR0, PSLVERR1;
  logic [31:0] PRDATA0, PRDATA1;

  int checks = 0;
  int errors = 0;

  // Slave models: ready after a programmable number of low-PREADY ACCESS cycles.
  int          s0_wait = 0, s1_wait = 0, s0_cnt = 0, s1_cnt = 0;
  logic [31:0] s0_regs [4] = '{default: 32'h0};
  logic [31:0] s1_rdata = 32'h0;
  logic        s1_err = 1'b0;

  apb_master_bridge dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY0(PREADY0), .PREADY1(PREADY1), .PRDATA0(PRDATA0), .PRDATA1(PRDATA1),
    .PSLVERR0(PSLVERR0), .PSLVERR1(PSLVERR1)
  );

  always #5 PCLK = ~PCLK;

  // Slave 0 behaves like a tiny adder: regs by PADDR[14:13], index 0 reads regs[1]+regs[2].
  assign PREADY0  = PSEL0 & PENABLE & (s0_cnt >= s0_wait);
  assign PRDATA0  = (PADDR[14:13] == 2'd0) ? (s0_regs[1] + s0_regs[2]) : s0_regs[PADDR[14:13]];
  assign PSLVERR0 = 1'b0;
  assign PREADY1  = PSEL1 & PENABLE & (s1_cnt >= s1_wait);
  assign PRDATA1  = s1_rdata;
  assign PSLVERR1 = s1_err;

  // Wait-state counters and slave 0 register writes.
  always @(posedge PCLK) begin
    if (!PENABLE) s0_cnt <= 0;
    else if (PSEL0 && !PREADY0) s0_cnt <= s0_cnt + 1;
    if (!PENABLE) s1_cnt <= 0;
    else if (PSEL1 && !PREADY1) s1_cnt <= s1_cnt + 1;
    if (PSEL0 && PENABLE && PREADY0 && PWRITE) s0_regs[PADDR[14:13]] <= PWDATA;
  end

  // Issue one command and observe until rsp_valid (lat = cycles after the accept edge, -1 = none).
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int budget,
                         output int lat, output int n_setup, output int n_acc, output int n_other,
                         output logic err, output logic [31:0] rdata, output logic idle_ok);
    logic tgt;
    tgt = a[15];
    lat = -1; n_setup = 0; n_acc = 0; n_other = 0; err = 1'b0; rdata = 32'h0; idle_ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      logic ps, po;
      ps = tgt ? PSEL1 : PSEL0;
      po = tgt ? PSEL0 : PSEL1;
      if (po) n_other++;
      if (rsp_valid) begin
        lat = c; err = rsp_err; rdata = rsp_rdata;
        idle_ok = !PSEL0 && !PSEL1 && !PENABLE && cmd_ready;
        break;
      end
      if (ps && !PENABLE) n_setup++;
      if (ps && PENABLE) n_acc++;
      @(posedge PCLK); #1;
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    checks++;
    if ({PSEL0, PSEL1, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== 100'h0) begin
      errors++; $display("FAIL reset_outputs psel0=%b psel1=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b expected all 0",
                         PSEL0, PSEL1, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b expected 0", cmd_ready); end
    PRESET = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    int lat, ns, na, no; logic e, ok; logic [31:0] rd;
    s0_wait = 0;
    run_cmd(1'b1, 32'h0000_0000, 32'h5, 20, lat, ns, na, no, e, rd, ok);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr0_latency got %0d expected 3", lat); end
    checks++; if (ns !== 1) begin errors++; $display("FAIL wr0_setup_cycles got %0d expected 1", ns); end
    checks++; if (na !== 1) begin errors++; $display("FAIL wr0_access_cycles got %0d expected 1", na); end
    checks++; if (no !== 0) begin errors++; $display("FAIL wr0_psel1_cycles got %0d expected 0", no); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr0_err got %b expected 0", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr0_rdata got %h expected 0", rd); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr0_idle_at_rsp got %b expected 1", ok); end
    checks++;
    if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h0, 32'h5}) begin
      errors++; $display("FAIL wr0_held_bus got pwrite=%b paddr=%h pwdata=%h expected 1/00000000/00000005", PWRITE, PADDR, PWDATA);
    end
  endtask

  task automatic test_read_wait_states();
    int lat, ns, na, no; logic e, ok; logic [31:0] rd;
    s1_wait = 3; s1_rdata = 32'hDEAD_BEEF; s1_err = 1'b0;
    run_cmd(1'b0, 32'h0000_8000, 32'h0, 30, lat, ns, na, no, e, rd, ok);
    checks++; if (na !== 4) begin errors++; $display("FAIL rd1_access_cycles got %0d expected 4", na); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL rd1_latency got %0d expected 6", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd1_rdata got %h expected deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rd1_err got %b expected 0", e); end
    checks++; if (no !== 0) begin errors++; $display("FAIL rd1_psel0_cycles got %0d expected 0", no); end
    s1_wait = 0;
  endtask

  task automatic test_timeout();
    int lat, ns, na, no; logic e, ok; logic [31:0] rd;
    s0_wait = 1000;
    run_cmd(1'b0, 32'h0000_0010, 32'h0, 40, lat, ns, na, no, e, rd, ok);
    checks++; if (na !== 16) begin errors++; $display("FAIL tmo_access_cycles got %0d expected 16", na); end
    checks++; if (lat !== 18) begin errors++; $display("FAIL tmo_latency got %0d expected 18", lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL tmo_err got %b expected 1", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h expected 0", rd); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_psel_dropped got %b expected 1", ok); end
    s0_wait = 0;
  endtask

  task automatic test_back_to_back();
    int lat, ns, na, no; logic e, ok; logic [31:0] rd;
    s0_wait = 0;
    run_cmd(1'b1, 32'h0000_4000, 32'h0C, 20, lat, ns, na, no, e, rd, ok);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_wr_latency got %0d expected 3", lat); end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_rsp got %b expected 1", ok); end
    run_cmd(1'b0, 32'h0000_0000, 32'h0, 20, lat, ns, na, no, e, rd, ok);
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_rd_latency got %0d expected 3", lat); end
    checks++; if (rd !== 32'h0000_000C) begin errors++; $display("FAIL b2b_rd_rdata got %h expected 0000000c", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL b2b_rd_err got %b expected 0", e); end
  endtask

  task automatic test_slverr();
    int lat, ns, na, no; logic e, ok; logic [31:0] rd;
    s1_wait = 0; s1_err = 1'b1; s1_rdata = 32'hA5A5_A5A5;
    run_cmd(1'b1, 32'h0000_8004, 32'h77, 20, lat, ns, na, no, e, rd, ok);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL err_wr_err got %b expected 1", e); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_wr_rdata got %h expected 0", rd); end
    s1_err = 1'b0; s1_rdata = 32'h1234_5678;
    run_cmd(1'b0, 32'h0000_8008, 32'h0, 20, lat, ns, na, no, e, rd, ok);
    checks++; if (lat !== 3) begin errors++; $display("FAIL err_next_latency got %0d expected 3", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_next_err got %b expected 0", e); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL err_next_rdata got %h expected 12345678", rd); end
  endtask

  task automatic test_reset_mid_transfer();
    int seen;
    s1_wait = 100;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_8000; cmd_wdata = 32'h0;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    checks++;
    if ({PSEL1, PENABLE} !== 2'b11) begin errors++; $display("FAIL rst_mid_in_access got %b expected 11", {PSEL1, PENABLE}); end
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if ({PSEL0, PSEL1, PENABLE, rsp_valid} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_outputs got %b expected 0000", {PSEL0, PSEL1, PENABLE, rsp_valid});
    end
    PRESET = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready got %b expected 1", cmd_ready); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) seen++;
      @(posedge PCLK); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d pulses expected 0", seen); end
    s1_wait = 0;
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    test_reset();
    test_write_zero_wait();
    test_read_wait_states();
    test_timeout();
    test_back_to_back();
    test_slverr();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
